// File: rtl/regbank_rsp_tx.sv
// UART response transmitter for the register-bank command path.
// It sends read data on a read completion and a fixed acknowledge byte on a write completion.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | line high; start the next frame if a request is pending or arriving
// S_START | start bit (0) for CLKS_PER_BIT cycles
// S_DATA  | 8 data bits, LSB first, each CLKS_PER_BIT cycles
// S_STOP  | stop bit (1); tx_done pulses in the following cycle
module regbank_rsp_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [7:0]  ACK_BYTE     = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rd_trigger,
    input  logic [7:0] i_regbank_rddata,
    input  logic       i_wr_trigger,
    output logic       o_tx,
    output logic       o_tx_busy,
    output logic       o_tx_done,
    output logic       o_tx_overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam logic [15:0] TIMER_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_timer;
    logic [15:0] w_timer_nxt;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_idx_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic [7:0]  r_rd_buf;
    logic [7:0]  w_rd_buf_nxt;
    logic        r_rd_pend;
    logic        w_rd_pend_nxt;
    logic        r_wr_pend;
    logic        w_wr_pend_nxt;
    logic        r_tx;
    logic        w_tx_nxt;
    logic        r_busy;
    logic        w_busy_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic        r_ovr;
    logic        w_ovr_nxt;
    logic        w_bit_end;

    assign w_bit_end = (r_timer == TIMER_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer + 16'd1;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_done_nxt    = 1'b0;

        // A trigger only lands in its slot when the slot is empty; otherwise it is dropped.
        w_rd_pend_nxt = r_rd_pend | i_rd_trigger;
        w_wr_pend_nxt = r_wr_pend | i_wr_trigger;
        w_rd_buf_nxt  = (i_rd_trigger && !r_rd_pend) ? i_regbank_rddata : r_rd_buf;
        w_ovr_nxt     = (i_rd_trigger && r_rd_pend) || (i_wr_trigger && r_wr_pend);

        case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
                if (r_rd_pend || i_rd_trigger) begin
                    w_shift_nxt   = r_rd_pend ? r_rd_buf : i_regbank_rddata;
                    w_rd_pend_nxt = 1'b0;
                    w_state_nxt   = S_START;
                end else if (r_wr_pend || i_wr_trigger) begin
                    w_shift_nxt   = ACK_BYTE;
                    w_wr_pend_nxt = 1'b0;
                    w_state_nxt   = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_timer_nxt   = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_timer_nxt = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_timer_nxt = '0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_timer_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase

        // Line level is computed from the next state so tx comes straight off a flop.
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE) || w_rd_pend_nxt || w_wr_pend_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_rd_buf  <= '0;
            r_rd_pend <= 1'b0;
            r_wr_pend <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_rd_buf  <= w_rd_buf_nxt;
            r_rd_pend <= w_rd_pend_nxt;
            r_wr_pend <= w_wr_pend_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_ovr     <= w_ovr_nxt;
        end
    end

    assign o_tx         = r_tx;
    assign o_tx_busy    = r_busy;
    assign o_tx_done    = r_done;
    assign o_tx_overrun = r_ovr;

endmodule

// File: tb/tb_regbank_rsp_tx.sv
// Directed bench for regbank_rsp_tx: a frame table at CLKS_PER_BIT=4 plus hand-written
// sequences for overrun, mid-frame reset and the CLKS_PER_BIT=2 boundary.
module tb_regbank_rsp_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd4, wr4, rd2, wr2;
    logic [7:0] d4, d2;
    logic       tx4, busy4, done4, ovr4;
    logic       tx2, busy2, done2, ovr2;

    int checks   = 0;
    int failures = 0;
    int ovr_cnt4 = 0;

    always #5 clk = ~clk;

    regbank_rsp_tx #(.CLKS_PER_BIT(4), .ACK_BYTE(8'hA5)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_rd_trigger(rd4), .i_regbank_rddata(d4),
        .i_wr_trigger(wr4), .o_tx(tx4), .o_tx_busy(busy4), .o_tx_done(done4),
        .o_tx_overrun(ovr4)
    );

    regbank_rsp_tx #(.CLKS_PER_BIT(2), .ACK_BYTE(8'hA5)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_rd_trigger(rd2), .i_regbank_rddata(d2),
        .i_wr_trigger(wr2), .o_tx(tx2), .o_tx_busy(busy2), .o_tx_done(done2),
        .o_tx_overrun(ovr2)
    );

    always @(negedge clk) if (ovr4 === 1'b1) ovr_cnt4++;

    typedef struct {
        logic       rd;
        logic [7:0] data;
        logic       wr;
        int         n_frames;
        logic [7:0] b1;
        logic [7:0] b2;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic f_tx(input int sel);
        return (sel == 2) ? tx2 : tx4;
    endfunction
    function automatic logic f_busy(input int sel);
        return (sel == 2) ? busy2 : busy4;
    endfunction
    function automatic logic f_done(input int sel);
        return (sel == 2) ? done2 : done4;
    endfunction

    // Called in the first cycle after the trigger edge; returns in the tx_done cycle.
    task automatic check_frame(input int sel, input int cpb, input logic [7:0] b,
                               input logic busy_after, input string nm);
        logic exp_bit;
        for (int bi = 0; bi < 10; bi++) begin
            if (bi == 0)      exp_bit = 1'b0;
            else if (bi == 9) exp_bit = 1'b1;
            else              exp_bit = b[bi-1];
            for (int c = 0; c < cpb; c++) begin
                chk({nm, " tx"}, f_tx(sel), exp_bit);
                chk({nm, " busy"}, f_busy(sel), 1'b1);
                chk({nm, " done_early"}, f_done(sel), 1'b0);
                tick();
            end
        end
        chk({nm, " done"}, f_done(sel), 1'b1);
        chk({nm, " idle_tx"}, f_tx(sel), 1'b1);
        chk({nm, " busy_at_done"}, f_busy(sel), busy_after);
    endtask

    initial begin
        int ovr_base;
        rst = 1'b1; rd4 = 0; wr4 = 0; d4 = '0; rd2 = 0; wr2 = 0; d2 = '0;

        vecs[0] = '{rd: 1'b1, data: 8'h3C, wr: 1'b0, n_frames: 1, b1: 8'h3C, b2: 8'h00};
        vecs[1] = '{rd: 1'b0, data: 8'h00, wr: 1'b1, n_frames: 1, b1: 8'hA5, b2: 8'h00};
        vecs[2] = '{rd: 1'b1, data: 8'h81, wr: 1'b1, n_frames: 2, b1: 8'h81, b2: 8'hA5};
        vecs[3] = '{rd: 1'b1, data: 8'hF0, wr: 1'b0, n_frames: 1, b1: 8'hF0, b2: 8'h00};

        tick(); tick();
        chk("rst tx", tx4, 1'b1);
        chk("rst busy", busy4, 1'b0);
        chk("rst done", done4, 1'b0);
        chk("rst ovr", ovr4, 1'b0);
        rst = 1'b0;
        tick();
        chk("post_rst tx", tx4, 1'b1);
        chk("post_rst busy", busy4, 1'b0);
        chk("post_rst tx2", tx2, 1'b1);

        foreach (vecs[i]) begin
            ovr_base = ovr_cnt4;
            rd4 = vecs[i].rd; d4 = vecs[i].data; wr4 = vecs[i].wr;
            tick();
            rd4 = 0; wr4 = 0; d4 = 8'hEE;
            check_frame(4, 4, vecs[i].b1, vecs[i].n_frames == 2, "vec_f1");
            if (vecs[i].n_frames == 2) begin
                tick();
                check_frame(4, 4, vecs[i].b2, 1'b0, "vec_f2");
            end
            tick(); tick();
            chk_int("vec ovr_none", ovr_cnt4, ovr_base);
        end

        // Overrun: both slots filled during a frame, then both re-triggered in one cycle.
        ovr_base = ovr_cnt4;
        rd4 = 1; d4 = 8'h0F;
        tick();
        rd4 = 1; d4 = 8'h11; wr4 = 1;
        tick();
        rd4 = 1; d4 = 8'h22; wr4 = 1;
        tick();
        rd4 = 0; wr4 = 0; d4 = 8'h00;
        chk("ovr pulse", ovr4, 1'b1);
        tick();
        chk("ovr single", ovr4, 1'b0);
        for (int c = 4; c < 41; c++) tick();
        chk("ovr f0 done", done4, 1'b1);
        chk("ovr f0 busy", busy4, 1'b1);
        tick();
        check_frame(4, 4, 8'h11, 1'b1, "ovr_rd");
        tick();
        check_frame(4, 4, 8'hA5, 1'b0, "ovr_wr");
        chk_int("ovr count", ovr_cnt4 - ovr_base, 1);
        tick();

        // Reset in the middle of data bit 3 (cycles 17..20 of a 0x00 frame).
        rd4 = 1; d4 = 8'h00;
        tick();
        rd4 = 0;
        for (int c = 1; c < 18; c++) tick();
        chk("mid bit3 tx", tx4, 1'b0);
        rst = 1'b1;
        tick();
        chk("abort tx", tx4, 1'b1);
        chk("abort busy", busy4, 1'b0);
        chk("abort done", done4, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 45; c++) begin
            tick();
            chk("abort no_done", done4, 1'b0);
            chk("abort idle_tx", tx4, 1'b1);
        end
        rd4 = 1; d4 = 8'h55;
        tick();
        rd4 = 0;
        check_frame(4, 4, 8'h55, 1'b0, "after_rst");
        tick();

        // CLKS_PER_BIT=2: 20-cycle frame, tx_done 21 cycles after the trigger.
        rd2 = 1; d2 = 8'hC3;
        tick();
        rd2 = 0;
        check_frame(2, 2, 8'hC3, 1'b0, "cpb2");
        tick();
        chk("cpb2 done_single", done2, 1'b0);
        chk("cpb2 ovr", ovr2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regbank_rsp_tx.md
Name: regbank_rsp_tx

Overview:
UART response transmitter for the register-bank command path. It is the outbound counterpart of the command receiver/decoder.
- On a read-command completion it serialises the register read data byte onto the UART TX line.
- On a write-command completion it sends a fixed acknowledge byte.
- It holds one pending request of each type while a frame is in flight.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535
ACK_BYTE, 8'hA5, byte sent in response to a write completion

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
rd_trigger  input  1  one-cycle pulse: read command complete; regbank_rddata valid in the same cycle
regbank_rddata  input  8  read data for the addressed register, sampled when rd_trigger=1
wr_trigger  input  1  one-cycle pulse: write command complete
tx  output  1  UART serial output; idle high
tx_busy  output  1  high while a frame is in flight or any request is pending
tx_done  output  1  one-cycle pulse after the stop bit of each frame ends
tx_overrun  output  1  one-cycle pulse when a trigger is dropped

Behaviour:
- Everything is synchronous to clk. rst is sampled on the clock edge only.
- While rst=1, and in the cycle after it: tx=1, tx_busy=0, tx_done=0, tx_overrun=0. The FSM is in IDLE, both pending flags are cleared, and the bit-timer, bit-index and shift register are all 0.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity. Each bit is exactly CLKS_PER_BIT cycles, so a frame is 10*CLKS_PER_BIT cycles.
- Request capture:
  - rd_trigger=1 and rd_pend=0: set rd_pend and capture regbank_rddata into rd_buf.
  - wr_trigger=1 and wr_pend=0: set wr_pend.
  - A trigger whose pending flag is already set is dropped. The old data is kept, and tx_overrun pulses in the next cycle. Both triggers dropped in the same cycle give a single pulse.
- Bypass: if IDLE and a trigger arrives with no request pending, that request is taken directly. It does not wait an extra cycle in the pending slot.
- Priority: read before write, including when rd_trigger and wr_trigger arrive in the same cycle. The unselected request remains pending.
- FSM states:
  - IDLE: tx=1. If any request is pending or arriving, load the shift register (rd_buf/regbank_rddata or ACK_BYTE), clear that pending flag, clear the timer, and go to START.
  - START: tx=0. When timer=CLKS_PER_BIT-1, go to DATA with bit index 0.
  - DATA: tx=shift[0]. At timer=CLKS_PER_BIT-1, shift right. If bit index=7, go to STOP; otherwise increment the index.
  - STOP: tx=1. At timer=CLKS_PER_BIT-1, go to IDLE and pulse tx_done in the next cycle.
- The timer resets to 0 on every bit boundary. There is no fractional-baud accumulation.
- Latency: trigger sampled at edge k → tx low from cycle k+1.
- Back-to-back: the next frame's start bit begins 1 cycle after the stop bit ends. That cycle is IDLE with tx=1, and tx_done=1 in that same cycle.
- tx_busy = (state≠IDLE) | rd_pend | wr_pend, as a registered or equivalent glitch-free output. It is 0 in the tx_done cycle only if nothing is pending.
- Reset mid-frame: the frame is aborted and tx returns to 1 on the next edge. Pending requests are discarded and no tx_done is issued.
- tx is driven from a flop; there is no combinational path from inputs to tx.

Test Plan:
1. CLKS_PER_BIT=4, rd_trigger with rddata=8'h3C at cycle 0 → tx=0 cycles 1-4; data bits 0,0,1,1,1,1,0,0 in 4-cycle slots over cycles 5-36; tx=1 cycles 37-40; tx_done=1 cycle 41; tx_busy=1 cycles 1-40.
2. wr_trigger alone → one frame carrying 8'hA5 (bits 1,0,1,0,0,1,0,1); tx_overrun never asserts.
3. rd_trigger (rddata=8'h81) and wr_trigger in the same cycle → frame 8'h81, then 1 idle-high cycle, then frame 8'hA5; two tx_done pulses 41 cycles apart; tx_busy stays high through the gap.
4. During a read frame, rd_trigger with 8'h11, then a second rd_trigger with 8'h22 → the second trigger is dropped and tx_overrun pulses once; the next frame sends 8'h11.
5. rst asserted at mid-data-bit 3 → tx=1 next cycle; tx_busy=0, no tx_done; a following rd_trigger with 8'h55 produces a clean full frame.
6. CLKS_PER_BIT=2 boundary → each bit lasts 2 cycles; total frame 20 cycles; tx_done 21 cycles after the trigger.
